dm_block_mover: RTL

//  Bus-master initiator on the data-memory (DM) port pair: the requester side of the DM read/write interface.

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_idx_stepper.sv | 40 ++++
 rtl/dm_block_mover.sv | 84 ++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared constants, state encoding and address helper for the DM block mover
package dm_pkg;
   localparam int DM_DEPTH = 16;
   localparam int DM_IDX_W = 4;
   localparam int DM_DW = 32;
   localparam int DM_AW = 32;
   localparam int DM_LEN_W = 5;
   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} dm_state_e;
   function automatic logic [DM_AW-1:0] idx2addr(input logic [DM_IDX_W-1:0] idx);
      return {{(DM_AW-DM_IDX_W-2){1'b0}}, idx, 2'b00};
   endfunction
endpackage

// File: rtl/dm_idx_stepper.sv
// dm_idx_stepper: source/destination word cursors and remaining-word count for a block command
module dm_idx_stepper
   import dm_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                step,
   input  logic                desc,
   input  logic [DM_IDX_W-1:0] src_idx,
   input  logic [DM_IDX_W-1:0] dst_idx,
   input  logic [DM_LEN_W-1:0] len,
   output logic [DM_IDX_W-1:0] cur_src,
   output logic [DM_IDX_W-1:0] cur_dst,
   output logic                last
);
   logic                dir_dn;
   logic [DM_LEN_W-1:0] rem;
   logic [DM_IDX_W-1:0] ofs;
   // descending walks start at the far end of the block; wraps modulo DEPTH
   assign ofs = desc ? DM_IDX_W'(len - DM_LEN_W'(1)) : '0;
   assign last = rem == DM_LEN_W'(1);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir_dn  <= 1'b0;
         rem     <= '0;
         cur_src <= '0;
         cur_dst <= '0;
      end else if (load) begin
         dir_dn  <= desc;
         rem     <= len;
         cur_src <= src_idx + ofs;
         cur_dst <= dst_idx + ofs;
      end else if (step) begin
         rem     <= rem - DM_LEN_W'(1);
         cur_src <= dir_dn ? cur_src - DM_IDX_W'(1) : cur_src + DM_IDX_W'(1);
         cur_dst <= dir_dn ? cur_dst - DM_IDX_W'(1) : cur_dst + DM_IDX_W'(1);
      end
   end
endmodule

// File: rtl/dm_block_mover.sv
// dm_block_mover: DM bus master executing COPY/FILL block commands with a running checksum
module dm_block_mover
   import dm_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                mode,
   input  logic [DM_IDX_W-1:0] src_idx,
   input  logic [DM_IDX_W-1:0] dst_idx,
   input  logic [DM_LEN_W-1:0] len,
   input  logic [DM_DW-1:0]    fill_val,
   output logic                busy,
   output logic                done,
   output logic [DM_DW-1:0]    checksum,
   output logic [DM_AW-1:0]    dm_addr,
   input  logic [DM_DW-1:0]    dm_rdata,
   output logic [DM_AW-1:0]    dm_addr_c,
   output logic [DM_DW-1:0]    dm_wdata,
   output logic                dm_wr_comp
);
   localparam logic [DM_LEN_W-1:0] MAX_LEN = DM_LEN_W'(DM_DEPTH);
   dm_state_e           state, state_nx;
   logic                mode_r, load, last, desc;
   logic [DM_DW-1:0]    fill_r, hold, wdata_sel;
   logic [DM_LEN_W-1:0] len_c;
   logic [DM_IDX_W-1:0] diff, cur_src, cur_dst;
   assign load = start && state == IDLE;
   assign len_c = len > MAX_LEN ? MAX_LEN : len;
   assign diff = dst_idx - src_idx;
   // destination ahead of source inside the block: walk backwards so sources are read before overwrite
   assign desc = mode == MODE_COPY && dst_idx != src_idx && {1'b0, diff} < len_c;
   assign wdata_sel = mode_r == MODE_FILL ? fill_r : hold;
   dm_idx_stepper u_stepper (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .step    (state == WRITE),
      .desc    (desc),
      .src_idx (src_idx),
      .dst_idx (dst_idx),
      .len     (len_c),
      .cur_src (cur_src),
      .cur_dst (cur_dst),
      .last    (last)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (start) state_nx = len_c == '0 ? DONE : (mode == MODE_FILL ? WRITE : READ);
         READ:  state_nx = WRITE;
         WRITE: state_nx = last ? DONE : (mode_r == MODE_FILL ? WRITE : READ);
         DONE:  state_nx = IDLE;
      endcase
   end
   always_comb begin
      busy       = state != IDLE;
      done       = state == DONE;
      dm_wr_comp = state == WRITE;
      dm_addr    = state == READ ? idx2addr(cur_src) : '0;
      dm_addr_c  = state == WRITE ? idx2addr(cur_dst) : '0;
      dm_wdata   = state == WRITE ? wdata_sel : '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_r   <= MODE_COPY;
         fill_r   <= '0;
         hold     <= '0;
         checksum <= '0;
      end else begin
         if (load) begin
            mode_r   <= mode;
            fill_r   <= fill_val;
            checksum <= '0;
         end
         if (state == READ) hold <= dm_rdata;
         if (state == WRITE) checksum <= checksum + wdata_sel;
      end
   end
endmodule
